// File: rtl/fp_simd_dispatch_pkg.sv
// fp_simd_dispatch_pkg: lane geometry, opcodes and FSM states shared by the dispatcher and the SIMD unit
package fp_simd_dispatch_pkg;
  localparam int LANES = 4;
  localparam int FP_W = 22;
  localparam int VW = LANES * FP_W;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_RCP = 3'd3;
  localparam logic [2:0] OP_RED_ADD = 3'd4;
  localparam logic [2:0] OP_RED_MUL = 3'd5;
  localparam logic [2:0] OP_LAST = OP_RED_MUL;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
endpackage

// File: rtl/fp_simd_dispatch_fifo.sv
// fp_simd_dispatch_fifo: DEPTH-entry command FIFO (DEPTH a power of 2), head always visible on dout
//   push/din  : write side, caller guarantees !full
//   pop/dout  : read side, dout is the head entry, caller guarantees !empty
//   full/empty/level : occupancy status, level in 0..DEPTH
module fp_simd_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fp_simd_dispatch.sv
// fp_simd_dispatch: command queue + issue sequencer in front of the 4-lane FP SIMD unit
//   s_valid/s_ready/s_opcode/s_in1/s_in2 : command input (s_ready = FIFO not full)
//   m_valid/m_ready/m_result/m_err       : single-slot result output, m_err marks timeout or illegal opcode
//   simd_en/simd_opcode/simd_in1/2       : issue pulse and operands held for the whole operation
//   simd_busy/simd_valid/simd_result     : SIMD status and result
//   o_level/o_idle                       : FIFO occupancy, fully idle flag
//   FP_DISPATCH_TAG_EN adds s_tag/m_tag, carried through the FIFO and returned with each result
module fp_simd_dispatch
  import fp_simd_dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 16
`ifdef FP_DISPATCH_TAG_EN
  , parameter int TAG_W = 4
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [2:0]                 s_opcode,
  input  logic [VW-1:0]              s_in1,
  input  logic [VW-1:0]              s_in2,
`ifdef FP_DISPATCH_TAG_EN
  input  logic [TAG_W-1:0]           s_tag,
  output logic [TAG_W-1:0]           m_tag,
`endif
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [VW-1:0]              m_result,
  output logic                       m_err,
  output logic                       simd_en,
  output logic [2:0]                 simd_opcode,
  output logic [VW-1:0]              simd_in1,
  output logic [VW-1:0]              simd_in2,
  input  logic                       simd_busy,
  input  logic                       simd_valid,
  input  logic [VW-1:0]              simd_result,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_idle
);
`ifdef FP_DISPATCH_TAG_EN
  localparam int CW = TAG_W + 3 + 2 * VW;
`else
  localparam int CW = 3 + 2 * VW;
`endif
  logic [CW-1:0] din, head;
  logic full, empty, go, bad;
  logic [2:0] h_op;
  logic [VW-1:0] h_in1, h_in2;
  logic [7:0] cnt;
  state_t state;
  assign din[2*VW+2:0] = {s_opcode, s_in1, s_in2};
  assign {h_op, h_in1, h_in2} = head[2*VW+2:0];
`ifdef FP_DISPATCH_TAG_EN
  logic [TAG_W-1:0] h_tag, cur_tag;
  assign din[CW-1 -: TAG_W] = s_tag;
  assign h_tag = head[CW-1 -: TAG_W];
`endif
  assign s_ready = !full;
  // the head leaves the FIFO only when its result will have a free slot to land in
  assign go = state == S_IDLE && !empty && !simd_busy && (!m_valid || m_ready);
  assign bad = h_op > OP_LAST;
  assign o_idle = empty && state == S_IDLE && !m_valid;
  fp_simd_dispatch_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(s_valid && s_ready),
    .din(din),
    .pop(go),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(o_level)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      simd_en <= 1'b0;
      simd_opcode <= '0;
      simd_in1 <= '0;
      simd_in2 <= '0;
      m_valid <= 1'b0;
      m_result <= '0;
      m_err <= 1'b0;
`ifdef FP_DISPATCH_TAG_EN
      cur_tag <= '0;
      m_tag <= '0;
`endif
    end else begin
      if (m_ready) m_valid <= 1'b0;
      case (state)
        S_IDLE:
          if (go && bad) begin
            m_valid <= 1'b1;
            m_result <= '0;
            m_err <= 1'b1;
`ifdef FP_DISPATCH_TAG_EN
            m_tag <= h_tag;
`endif
          end else if (go) begin
            state <= S_ISSUE;
            simd_en <= 1'b1;
            simd_opcode <= h_op;
            simd_in1 <= h_in1;
            simd_in2 <= h_in2;
`ifdef FP_DISPATCH_TAG_EN
            cur_tag <= h_tag;
`endif
          end
        S_ISSUE: begin
          state <= S_WAIT;
          simd_en <= 1'b0;
          cnt <= '0;
        end
        S_WAIT:
          // a result arriving on the last watchdog cycle still counts as success
          if (simd_valid || cnt == 8'(TIMEOUT - 1)) begin
            state <= S_IDLE;
            m_valid <= 1'b1;
            m_result <= simd_valid ? simd_result : '0;
            m_err <= !simd_valid;
`ifdef FP_DISPATCH_TAG_EN
            m_tag <= cur_tag;
`endif
          end else cnt <= cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fp_simd_dispatch.sv
// tb_fp_simd_dispatch: directed + randomized check of fp_simd_dispatch against an in-order command/result model
`timescale 1ns/1ps
module tb_fp_simd_dispatch;
  import fp_simd_dispatch_pkg::*;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
  localparam int TAG_W = 4;
  localparam int HANG = TIMEOUT + 6;
  localparam int NRAND = 150;
  localparam logic [FP_W-1:0] F1 = 22'h0FE000;
  localparam logic [FP_W-1:0] F2 = 22'h100000;
  localparam logic [FP_W-1:0] F3 = 22'h101000;
  typedef struct {
    logic [2:0] op;
    logic [VW-1:0] in1, in2, res;
    int d;
    logic [TAG_W-1:0] tag;
  } cmd_t;
  typedef struct {
    logic [VW-1:0] res;
    logic err;
    logic [TAG_W-1:0] tag;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic s_valid = 0, s_ready, m_valid, m_ready = 0, m_err;
  logic [2:0] s_opcode, simd_opcode;
  logic [VW-1:0] s_in1, s_in2, m_result, simd_in1, simd_in2;
  logic simd_en, simd_busy = 0, simd_valid = 0, o_idle;
  logic [VW-1:0] simd_result = '0;
  logic [$clog2(DEPTH):0] o_level;
`ifdef FP_DISPATCH_TAG_EN
  logic [TAG_W-1:0] m_tag;
`endif
  cmd_t cur, act;
  cmd_t issue_q[$];
  exp_t exp_q[$];
  int tests = 0, failed = 0, cyc = 0, push_cyc = 0, en_cyc = 0, en_cnt = 0, left = 0;
  int e0 = 0, t_en = 0, pushed = 0;
  logic active = 0, acc = 0, pe = 0;
  always #5 clk = ~clk;
  assign s_opcode = cur.op;
  assign s_in1 = cur.in1;
  assign s_in2 = cur.in2;
  fp_simd_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_opcode(s_opcode),
    .s_in1(s_in1),
    .s_in2(s_in2),
`ifdef FP_DISPATCH_TAG_EN
    .s_tag(cur.tag),
    .m_tag(m_tag),
`endif
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_result(m_result),
    .m_err(m_err),
    .simd_en(simd_en),
    .simd_opcode(simd_opcode),
    .simd_in1(simd_in1),
    .simd_in2(simd_in2),
    .simd_busy(simd_busy),
    .simd_valid(simd_valid),
    .simd_result(simd_result),
    .o_level(o_level),
    .o_idle(o_idle)
  );
  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [VW-1:0] rv();
    return VW'({$urandom, $urandom, $urandom});
  endfunction
  function automatic cmd_t mk(input logic [2:0] op, input logic [VW-1:0] in1, input logic [VW-1:0] in2,
                              input logic [VW-1:0] res, input int d, input logic [TAG_W-1:0] tag);
    cmd_t c;
    c.op = op; c.in1 = in1; c.in2 = in2; c.res = res; c.d = d; c.tag = tag;
    return c;
  endfunction
  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.op = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
    c.in1 = rv(); c.in2 = rv(); c.res = rv();
    c.d = ($urandom_range(0, 11) == 0) ? HANG : int'($urandom_range(1, TIMEOUT + 1));
    c.tag = TAG_W'($urandom);
    return c;
  endfunction
  task automatic model_reset();
    issue_q.delete();
    exp_q.delete();
    active = 0; pe = 0; simd_busy = 0; simd_valid = 0;
  endtask
  // one clock: account for this cycle's handshakes, advance, then play the SIMD unit for the new cycle
  task automatic step();
    acc = 0;
    if (s_valid && s_ready) begin
      exp_t e;
      e.err = (cur.op > OP_LAST) || (cur.d > TIMEOUT);
      e.res = e.err ? '0 : cur.res;
      e.tag = cur.tag;
      exp_q.push_back(e);
      if (cur.op <= OP_LAST) issue_q.push_back(cur);
      push_cyc = cyc;
      acc = 1;
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("extra_result", VW'(m_valid), VW'(0));
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("m_result", m_result, e.res);
        chk("m_err", VW'(m_err), VW'(e.err));
`ifdef FP_DISPATCH_TAG_EN
        chk("m_tag", VW'(m_tag), VW'(e.tag));
`endif
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (simd_en) begin
      chk("en_while_busy", VW'(simd_busy), VW'(0));
      chk("en_pulse_len", VW'(pe), VW'(0));
      if (issue_q.size() == 0) chk("spurious_en", VW'(simd_en), VW'(0));
      else begin
        act = issue_q.pop_front();
        chk("issue_op", VW'(simd_opcode), VW'(act.op));
        chk("issue_in1", simd_in1, act.in1);
        chk("issue_in2", simd_in2, act.in2);
        en_cnt++; en_cyc = cyc; active = 1; left = act.d;
        simd_busy = 1; simd_valid = 0; simd_result = act.res;
      end
    end else if (active) begin
      if (cyc - en_cyc <= TIMEOUT) begin
        chk("held_op", VW'(simd_opcode), VW'(act.op));
        chk("held_in1", simd_in1, act.in1);
        chk("held_in2", simd_in2, act.in2);
      end
      left--;
      simd_valid = (left == 0) && (act.d != HANG);
      if (left == 0) active = 0;
    end else begin
      simd_busy = 0;
      simd_valid = 0;
    end
    pe = simd_en;
  endtask
  task automatic wait_mv(input string tag);
    for (int n = 0; n < 100 && !m_valid; n++) step();
    chk({tag, "_mvalid"}, VW'(m_valid), VW'(1));
  endtask
  task automatic drain(input string tag);
    m_ready = 1;
    for (int n = 0; n < 300 && (exp_q.size() > 0 || !o_idle); n++) step();
    chk({tag, "_drain"}, VW'(exp_q.size() == 0 && o_idle), VW'(1));
  endtask
  initial begin
    cur = mk(OP_ADD, '0, '0, '0, 1, '0);
    #3;
    chk("rst_m_valid", VW'(m_valid), VW'(0));
    chk("rst_s_ready", VW'(s_ready), VW'(1));
    chk("rst_o_idle", VW'(o_idle), VW'(1));
    chk("rst_simd_en", VW'(simd_en), VW'(0));
    chk("rst_level", VW'(o_level), VW'(0));
    chk("rst_m_result", m_result, '0);
    chk("rst_m_err", VW'(m_err), VW'(0));
    #20 rst_n = 1;
    // lane0 1.0 + 2.0, SIMD answers 4 cycles after issue
    m_ready = 1; e0 = en_cnt;
    cur = mk(OP_ADD, {F1, {(VW-FP_W){1'b0}}}, {F2, {(VW-FP_W){1'b0}}}, {F3, {(VW-FP_W){1'b0}}}, 4, 3);
    s_valid = 1; step(); s_valid = 0;
    chk("add_no_bypass", VW'(simd_en), VW'(0));
    step();
    chk("add_en_lat2", VW'(simd_en), VW'(1));
    wait_mv("add");
    chk("add_result_lat", VW'(cyc - en_cyc), VW'(5));
    chk("add_lane0", VW'(m_result[VW-1 -: FP_W]), VW'(F3));
    chk("add_err", VW'(m_err), VW'(0));
    chk("add_one_pulse", VW'(en_cnt - e0), VW'(1));
    step();
    chk("add_mvalid_drop", VW'(m_valid), VW'(0));
    // result slot occupied and unread: the FIFO fills to DEPTH and refuses the fifth command
    m_ready = 0;
    cur = mk(OP_SUB, rv(), rv(), rv(), 2, 1); s_valid = 1; step(); s_valid = 0;
    wait_mv("fill_pre");
    for (int i = 0; i < 4; i++) begin
      cur = mk(3'(i), rv(), rv(), rv(), 1 + i, TAG_W'(i));
      s_valid = 1;
      chk("fill_ready", VW'(s_ready), VW'(1));
      step();
    end
    cur = mk(OP_RED_ADD, rv(), rv(), rv(), 3, 4'hA);
    chk("full_ready", VW'(s_ready), VW'(0));
    chk("full_level", VW'(o_level), VW'(4));
    chk("full_not_idle", VW'(o_idle), VW'(0));
    m_ready = 1; acc = 0;
    for (int n = 0; n < 100 && !acc; n++) step();
    chk("fill_5th_accept", VW'(acc), VW'(1));
    s_valid = 0;
    drain("fill");
    // illegal opcode: aborted without issue, result one cycle after pop
    e0 = en_cnt;
    cur = mk(3'd7, rv(), rv(), rv(), 1, 5); s_valid = 1; step(); s_valid = 0;
    chk("ill_not_yet", VW'(m_valid), VW'(0));
    step();
    chk("ill_mvalid", VW'(m_valid), VW'(1));
    chk("ill_err", VW'(m_err), VW'(1));
    chk("ill_result", m_result, '0);
    drain("ill");
    chk("ill_no_en", VW'(en_cnt - e0), VW'(0));
    // SIMD never answers: watchdog aborts, next command waits for simd_busy to fall
    cur = mk(OP_RCP, rv(), rv(), rv(), HANG, 6); s_valid = 1; step();
    cur = mk(OP_ADD, rv(), rv(), rv(), 3, 7); step(); s_valid = 0;
    wait_mv("to");
    chk("to_lat", VW'(cyc - en_cyc), VW'(TIMEOUT + 1));
    chk("to_err", VW'(m_err), VW'(1));
    chk("to_result", m_result, '0);
    t_en = en_cyc;
    drain("to");
    chk("to_next_after_busy", VW'(en_cyc - t_en), VW'(HANG + 2));
    // boundary: answer on the last watchdog cycle wins, one cycle later is an abort
    cur = mk(OP_MUL, rv(), rv(), rv(), TIMEOUT, 8); s_valid = 1; step(); s_valid = 0;
    wait_mv("edge_ok");
    chk("edge_ok_lat", VW'(cyc - en_cyc), VW'(TIMEOUT + 1));
    chk("edge_ok_err", VW'(m_err), VW'(0));
    drain("edge_ok");
    cur = mk(OP_MUL, rv(), rv(), rv(), TIMEOUT + 1, 9); s_valid = 1; step(); s_valid = 0;
    wait_mv("edge_late");
    chk("edge_late_err", VW'(m_err), VW'(1));
    drain("edge_late");
    // asynchronous reset while waiting on the SIMD unit
    cur = mk(OP_MUL, rv(), rv(), rv(), 10, 1); s_valid = 1; step();
    cur = mk(OP_SUB, rv(), rv(), rv(), 2, 2); step(); s_valid = 0;
    chk("rw_en", VW'(simd_en), VW'(1));
    step(); step(); step();
    chk("rw_level", VW'(o_level), VW'(1));
    #2 rst_n = 0;
    #1;
    chk("rw_m_valid", VW'(m_valid), VW'(0));
    chk("rw_level0", VW'(o_level), VW'(0));
    chk("rw_simd_en", VW'(simd_en), VW'(0));
    chk("rw_idle", VW'(o_idle), VW'(1));
    model_reset();
    #2 rst_n = 1;
    cur = mk(OP_RED_MUL, rv(), rv(), rv(), 3, 4); s_valid = 1; step(); s_valid = 0;
    drain("rw_after");
`ifdef FP_DISPATCH_TAG_EN
    cur = mk(OP_ADD, rv(), rv(), rv(), 2, 3); s_valid = 1; step();
    cur = mk(OP_SUB, rv(), rv(), rv(), 2, 9); step(); s_valid = 0;
    wait_mv("tag_a");
    chk("tag_first", VW'(m_tag), VW'(3));
    step();
    wait_mv("tag_b");
    chk("tag_second", VW'(m_tag), VW'(9));
    drain("tag");
`endif
    // randomized traffic with backpressure, illegal opcodes and timeouts mixed in
    pushed = 0;
    for (int n = 0; n < 20000 && (pushed < NRAND || exp_q.size() > 0 || !o_idle); n++) begin
      if (!s_valid && pushed < NRAND && $urandom_range(0, 3) != 0) begin
        cur = rnd_cmd();
        s_valid = 1;
      end
      m_ready = $urandom_range(0, 3) != 0;
      step();
      if (acc) begin
        pushed++;
        s_valid = 0;
      end
    end
    chk("rand_done", VW'(pushed == NRAND && exp_q.size() == 0 && o_idle), VW'(1));
    chk("rand_level", VW'(o_level), VW'(0));
    chk("rand_ready", VW'(s_ready), VW'(1));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
